pc_fetch_unit: RTL and testbench

- Instruction-fetch stage that owns the program counter.
- Drives the current PC to the +4 adder and to instruction memory, and takes the incremented PC back from the adder as its sequential next-PC.
- Handles a ready-based instruction-memory handshake, hazard stalls, branch/jump redirects and flushes.
- Loads the IF/ID pipeline register consumed by the decode stage.

---
 rtl/pc_fetch_unit.sv | 132 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Instruction-fetch stage. Owns the program counter, drives it to the
//   external +4 adder and to instruction memory, and loads the IF/ID
//   pipeline register for the decode stage.
//
// Ports
//   clk             system clock, all state changes on the rising edge
//   rst_n           synchronous active-low reset
//   pc_out          current PC (adder input and imem address)
//   pc_plus4_in     pc_out + 4 returned from the adder
//   imem_req        fetch request for pc_out (depends only on state)
//   imem_ready      imem_rdata valid this cycle
//   imem_rdata      instruction word
//   stall           hazard stall: freezes PC and IF/ID
//   redirect_valid  taken branch/jump from a later stage
//   redirect_target new PC for the redirect
//   flush           squash the instruction held in IF/ID
//   ifid_pc4        registered PC+4 of the fetched instruction
//   ifid_instr      registered instruction
//   ifid_valid      IF/ID holds a real instruction (0 = bubble)
//   misaligned_err  one-cycle pulse when redirect_target[1:0] != 0
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc_out,
    input  logic [31:0] pc_plus4_in,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        flush,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic        misaligned_err
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        WAIT,
        DRAIN
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pending;
    logic [31:0] r_ifid_pc4;
    logic [31:0] r_ifid_instr;
    logic        r_ifid_valid;
    logic        r_misaligned;

    logic [31:0] w_target;

    assign w_target       = redirect_target & ~32'h3;

    assign pc_out         = r_pc;
    assign imem_req       = (r_state != BOOT);
    assign ifid_pc4       = r_ifid_pc4;
    assign ifid_instr     = r_ifid_instr;
    assign ifid_valid     = r_ifid_valid;
    assign misaligned_err = r_misaligned;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= BOOT;
            r_pc         <= RESET_PC;
            r_pending    <= '0;
            r_ifid_pc4   <= '0;
            r_ifid_instr <= '0;
            r_ifid_valid <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= redirect_valid && (redirect_target[1:0] != 2'b00);

            if (redirect_valid) begin
                r_ifid_valid <= 1'b0;
                case (r_state)
                    // An outstanding request that has not been answered must
                    // be drained before the new PC can be presented.
                    WAIT, DRAIN: begin
                        if (imem_ready) begin
                            r_pc    <= w_target;
                            r_state <= FETCH;
                        end else begin
                            r_pending <= w_target;
                            r_state   <= DRAIN;
                        end
                    end
                    default: begin
                        r_pc    <= w_target;
                        r_state <= FETCH;
                    end
                endcase
            end else if (!stall) begin
                case (r_state)
                    BOOT: r_state <= FETCH;
                    FETCH, WAIT: begin
                        if (imem_ready) begin
                            r_ifid_instr <= imem_rdata;
                            r_ifid_pc4   <= pc_plus4_in;
                            r_ifid_valid <= 1'b1;
                            r_pc         <= pc_plus4_in;
                            r_state      <= FETCH;
                        end else begin
                            r_ifid_valid <= 1'b0;
                            r_state      <= WAIT;
                        end
                    end
                    DRAIN: begin
                        // Response belongs to the squashed path; drop it.
                        if (imem_ready) begin
                            r_pc    <= r_pending;
                            r_state <= FETCH;
                        end
                    end
                    default: r_state <= BOOT;
                endcase
            end

            // Flush wins over capture and stall; PC path is unaffected.
            if (flush) begin
                r_ifid_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
//   Directed stimulus for pc_fetch_unit. The stimulus process pushes the
//   hand-computed IF/ID contents of every instruction it expects to be
//   captured; an independent monitor pops one entry each time IF/ID presents
//   a new valid instruction. PC, imem_req and misaligned_err are checked
//   inline. Memory returns {16'hC0DE, addr[15:0]} for address pc_out.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_in;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        flush;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        misaligned_err;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q[$];

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_out         (pc_out),
        .pc_plus4_in    (pc_plus4_in),
        .imem_req       (imem_req),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .flush          (flush),
        .ifid_pc4       (ifid_pc4),
        .ifid_instr     (ifid_instr),
        .ifid_valid     (ifid_valid),
        .misaligned_err (misaligned_err)
    );

    assign pc_plus4_in = pc_out + 32'd4;
    assign imem_rdata  = {16'hC0DE, pc_out[15:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc4, input logic [31:0] instr);
        exp_q.push_back({pc4, instr});
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Monitor: a new IF/ID output is a valid entry that differs from what was
    // held on the previous sample (a stall holds the same entry).
    logic        prev_valid = 1'b0;
    logic [63:0] prev_data  = '0;
    logic [63:0] exp_e;
    always @(negedge clk) begin
        if (rst_n && ifid_valid && (!prev_valid || prev_data !== {ifid_pc4, ifid_instr})) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: actual pc4=%h instr=%h required none", ifid_pc4, ifid_instr);
            end else begin
                exp_e = exp_q.pop_front();
                chk("sb_pc4", ifid_pc4, exp_e[63:32]);
                chk("sb_instr", ifid_instr, exp_e[31:0]);
            end
        end
        prev_valid = rst_n && ifid_valid;
        prev_data  = {ifid_pc4, ifid_instr};
    end

    initial begin
        rst_n = 1'b0; imem_ready = 1'b1; stall = 1'b0;
        redirect_valid = 1'b0; redirect_target = '0; flush = 1'b0;
        tick(); tick();
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_pc4", ifid_pc4, 32'h0);
        chk("rst_instr", ifid_instr, 32'h0);
        chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
        chk("rst_err", {31'b0, misaligned_err}, 32'h0);
        rst_n = 1'b1;
        tick();                                   // BOOT edge passed
        chk("boot_req", {31'b0, imem_req}, 32'h1);
        chk("boot_pc", pc_out, 32'h0);
        push(32'h4, 32'hC0DE_0000);
        tick(); chk("seq_pc4", pc_out, 32'h4); push(32'h8, 32'hC0DE_0004);
        tick(); chk("seq_pc8", pc_out, 32'h8); push(32'hC, 32'hC0DE_0008);
        tick(); chk("seq_pcC", pc_out, 32'hC); push(32'h10, 32'hC0DE_000C);
        tick(); chk("seq_pc10", pc_out, 32'h10);

        // memory not ready for two cycles at 0x10
        imem_ready = 1'b0;
        tick(); chk("wait1_pc", pc_out, 32'h10); chk("wait1_valid", {31'b0, ifid_valid}, 32'h0);
        tick(); chk("wait2_pc", pc_out, 32'h10); chk("wait2_valid", {31'b0, ifid_valid}, 32'h0);
        imem_ready = 1'b1; push(32'h14, 32'hC0DE_0010);
        tick(); chk("wait_done_pc", pc_out, 32'h14); push(32'h18, 32'hC0DE_0014);
        tick(); push(32'h1C, 32'hC0DE_0018);
        tick(); push(32'h20, 32'hC0DE_001C);
        tick(); chk("pre_stall_pc", pc_out, 32'h20);

        // stall three cycles with memory ready
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", pc_out, 32'h20);
            chk("stall_pc4", ifid_pc4, 32'h20);
            chk("stall_valid", {31'b0, ifid_valid}, 32'h1);
            chk("stall_req", {31'b0, imem_req}, 32'h1);
        end
        stall = 1'b0; push(32'h24, 32'hC0DE_0020);
        tick(); chk("post_stall_pc", pc_out, 32'h24);

        // redirect beats stall
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h100;
        tick();
        chk("redir_pc", pc_out, 32'h100);
        chk("redir_valid", {31'b0, ifid_valid}, 32'h0);
        chk("redir_err", {31'b0, misaligned_err}, 32'h0);
        stall = 1'b0; redirect_valid = 1'b0; push(32'h104, 32'hC0DE_0100);
        tick(); chk("redir_next_pc", pc_out, 32'h104);

        // misaligned redirect
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h102;
        tick();
        chk("mis_pc", pc_out, 32'h100);
        chk("mis_err", {31'b0, misaligned_err}, 32'h1);
        chk("mis_valid", {31'b0, ifid_valid}, 32'h0);
        stall = 1'b0; redirect_valid = 1'b0; push(32'h104, 32'hC0DE_0100);
        tick();
        chk("mis_err_pulse", {31'b0, misaligned_err}, 32'h0);
        chk("mis_next_pc", pc_out, 32'h104);

        // redirect while WAITing on memory: stale response must be dropped
        imem_ready = 1'b0;
        tick();
        redirect_valid = 1'b1; redirect_target = 32'h200;
        tick();
        redirect_valid = 1'b0;
        chk("drain_pc_hold", pc_out, 32'h104);
        chk("drain_valid", {31'b0, ifid_valid}, 32'h0);
        chk("drain_req", {31'b0, imem_req}, 32'h1);
        tick();
        imem_ready = 1'b1;
        tick();
        chk("drain_done_pc", pc_out, 32'h200);
        chk("drain_done_valid", {31'b0, ifid_valid}, 32'h0);
        push(32'h204, 32'hC0DE_0200);
        tick(); chk("drain_next_pc", pc_out, 32'h204);

        // wrap-around
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_pre_pc", pc_out, 32'hFFFF_FFFC);
        push(32'h0, 32'hC0DE_FFFC);
        tick();
        chk("wrap_pc", pc_out, 32'h0);
        chk("wrap_valid", {31'b0, ifid_valid}, 32'h1);

        // flush coincident with capture: instruction dropped, PC advances
        flush = 1'b1;
        tick();
        chk("flush_pc", pc_out, 32'h4);
        chk("flush_valid", {31'b0, ifid_valid}, 32'h0);
        flush = 1'b0; push(32'h8, 32'hC0DE_0004);
        tick(); chk("flush_next_pc", pc_out, 32'h8);

        imem_ready = 1'b0;
        tick(); tick(); tick();
        chk("sb_empty", exp_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
